mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between two requesters: the instruction-fetch stage (IF) and the data-access stage (MEM) of the 5-stage pipeline CPU.
- Grants one requester per arbitration, sequences a fixed-latency memory access, and returns read data or write completion to the owner.
- Requesters stall while their request is pending. At most one transaction is outstanding.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from mem_en to valid mem_rdata; legal range 1..7.
- STARVE_MAX, 4, consecutive IF losses before IF is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  IF request; held with if_addr stable until if_gnt.
- if_addr  in  ADDR_W  IF read address.
- if_gnt  out  1  IF request accepted this cycle.
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DATA_W  IF read data.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle pulse; read data valid, or write complete.
- d_rdata  out  DATA_W  data read result; 0 for writes.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.

Behaviour:
- Reset (rst high at posedge):
  - state = IDLE, latency counter = 0, starvation counter = 0, rdata registers = 0.
  - All outputs are 0 in the cycle following reset.
  - A transaction in flight when rst rises is dropped: no rvalid is produced and nothing is retried.
- FSM states: IDLE, WAIT.
- IDLE:
  - If any request is present, the arbiter picks a winner combinationally in that cycle.
  - For the winner: the matching gnt=1 and mem_en=1; mem_addr/mem_we/mem_wdata are driven from the winner (mem_we=0 for IF).
  - The owner is latched and the FSM moves to WAIT with counter = MEM_LAT-1.
  - With no request present, all mem_* outputs are 0.
- WAIT:
  - No gnt is given and mem_en=0. The counter decrements each cycle.
  - In the cycle where the counter reads 0, mem_rdata is valid. It is registered into the owner's rdata, and the FSM moves to IDLE.
- Response timing:
  - Owner's rvalid is high for exactly one cycle: cycle T+MEM_LAT+1, where T is the grant cycle.
  - A new grant may occur in that same cycle.
  - Throughput is one transaction per MEM_LAT+1 cycles.
- Priority:
  - Data wins over IF by default.
  - Each IDLE cycle where if_req=1 and data wins increments the starvation counter, saturating at STARVE_MAX.
  - When the counter equals STARVE_MAX and both requests are present, IF wins.
  - Any IF grant clears the counter to 0.
- if_rdata / d_rdata hold their last value between pulses. d_rdata is set to 0 on write completion.
- A request deasserted before its grant is a protocol violation. Behaviour is undefined; no checker is included.
- gnt and rvalid never assert in the same cycle for the same requester unless back-to-back (response cycle plus a new grant), which is legal.

Optional Feature:
- ARB_ROUND_ROBIN_EN
  - Defined: the starvation counter is removed. On contention the winner is the requester that did not win the most recent grant (reset value: last = IF, so data wins the first tie). A lone requester always wins.
  - Undefined: data priority with the STARVE_MAX escape, as described under Behaviour.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, WAIT};
  - owner constants OWN_IF=1'b0, OWN_D=1'b1;
  - latency counter width LAT_W=3.
- Sub-module mem_arb_pick: combinational winner selection from if_req, d_req, starvation-counter-saturated flag and last-owner flag, under the ARB_ROUND_ROBIN_EN macro. Starvation and last-owner state stay in the parent.

Test Plan:
- Single IF read, MEM_LAT=2: if_req with if_addr=0x10, memory returns 0xAAAA0001 → if_gnt at cycle 0, mem_en at cycle 0 only, if_rvalid at cycle 3 with if_rdata=0xAAAA0001.
- Data write: d_req, d_we=1, d_addr=0x40, d_wdata=0x1234 → mem_we=1, mem_wdata=0x1234 at grant; d_rvalid 3 cycles later with d_rdata=0.
- Contention, STARVE_MAX=4: both requests held continuously → grant order D,D,D,D,IF,D,… with the starvation counter cleared after the IF grant.
- Back-to-back: d_req held for 3 transactions → grants at cycles 0, 3, 6; each rvalid coincides with the next grant.
- Reset mid-WAIT: rst asserted 1 cycle after grant → no rvalid, state IDLE, all outputs 0; a subsequent if_req is granted normally.
- ARB_ROUND_ROBIN_EN defined, both requests held → grants alternate D, IF, D, IF.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
// Imported by the arbiter, its picker and its interface users.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam int LAT_W = 3;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and memory side signals of the arbiter.
// slave = arbiter view, master = requesters/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection for the memory port.
// ARB_ROUND_ROBIN_EN: tie goes to the loser of the last grant.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req_i,
  input  logic d_req_i,
  input  logic starve_sat_i,
  input  logic last_own_i,
  output logic any_o,
  output logic own_o
);

`ifdef ARB_ROUND_ROBIN_EN
  logic unused_sat;
  assign unused_sat = starve_sat_i;
`else
  logic unused_last;
  assign unused_last = last_own_i;
`endif

  // pick owner; a lone requester always wins
  always_comb begin
    any_o = if_req_i | d_req_i;
    own_o = OWN_IF;
    unique case (1'b1)
      (if_req_i && d_req_i): begin
`ifdef ARB_ROUND_ROBIN_EN
        own_o = (last_own_i == OWN_IF) ? OWN_D : OWN_IF;
`else
        own_o = starve_sat_i ? OWN_IF : OWN_D;
`endif
      end
      (d_req_i && !if_req_i): own_o = OWN_D;
      default:                own_o = OWN_IF;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory between IF and MEM.
// Optional macro ARB_ROUND_ROBIN_EN replaces the starvation escape.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  state_e             state_q, state_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;
  logic               own_q, we_q;
  logic               any_req, win_own;
  logic               grant, done;
  logic               gnt_if, gnt_d;
  logic               starve_sat, last_own;
  logic               if_rvalid_q, d_rvalid_q;
  logic [DATA_W-1:0]  if_rdata_q, d_rdata_q;
  logic [ADDR_W-1:0]  addr_sel;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q;
  assign starve_sat = 1'b0;
  assign last_own   = last_q;

  // remember the most recent winner for tie-breaks
  always_ff @(posedge clk) begin
    if (rst)        last_q <= OWN_IF;
    else if (grant) last_q <= win_own;
  end
`else
  logic [3:0] starve_q;
  assign starve_sat = (starve_q == 4'(STARVE_MAX));
  assign last_own   = OWN_IF;

  // count IF losses; saturate, clear on any IF grant
  always_ff @(posedge clk) begin
    if (rst)
      starve_q <= '0;
    else if (gnt_if)
      starve_q <= '0;
    else if (gnt_d && bus.if_req && !starve_sat)
      starve_q <= starve_q + 4'd1;
  end
`endif

  mem_arb_pick u_pick (
    .if_req_i     (bus.if_req),
    .d_req_i      (bus.d_req),
    .starve_sat_i (starve_sat),
    .last_own_i   (last_own),
    .any_o        (any_req),
    .own_o        (win_own)
  );

  assign grant  = (state_q == IDLE) && any_req && !rst;
  assign gnt_if = grant && (win_own == OWN_IF);
  assign gnt_d  = grant && (win_own == OWN_D);
  assign done   = (state_q == WAIT) && (cnt_q == '0);

  // state and latency counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state: count down the fixed memory latency
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = WAIT;
          cnt_d   = LAT_W'(MEM_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - LAT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // grant and memory strobe outputs, driven from the winner
  always_comb begin
    addr_sel      = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    bus.if_gnt    = gnt_if;
    bus.d_gnt     = gnt_d;
    bus.mem_en    = grant;
    if (gnt_d) begin
      addr_sel      = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
      bus.mem_we    = bus.d_we;
    end else if (gnt_if) begin
      addr_sel = bus.if_addr;
    end
    bus.mem_addr = addr_sel;
  end

  // owner latch and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      own_q       <= OWN_IF;
      we_q        <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_rvalid_q <= done && (own_q == OWN_IF);
      d_rvalid_q  <= done && (own_q == OWN_D);
      if (grant) begin
        own_q <= win_own;
        we_q  <= gnt_d && bus.d_we;
      end
      if (done && (own_q == OWN_IF))
        if_rdata_q <= bus.mem_rdata;
      if (done && (own_q == OWN_D))
        d_rdata_q <= we_q ? '0 : bus.mem_rdata;
    end
  end

  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors, contention order and
// randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW),
    .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        rs;
    logic        ifr;
    logic [31:0] ia;
    logic        dr;
    logic        dwe;
    logic [31:0] da;
    logic [31:0] dw;
    logic [5:0]  f;
    logic [31:0] ma;
    logic [31:0] mw;
    logic [31:0] ird;
    logic [31:0] drd;
  } vec_t;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = -1;
  int          due = -1;
  logic [31:0] due_d;
  logic [31:0] mem [64];
  vec_t        vq[$];

  function automatic vec_t V(
    input logic ifr, input logic [31:0] ia,
    input logic dr, input logic dwe,
    input logic [31:0] da, input logic [31:0] dw,
    input logic [5:0] f,
    input logic [31:0] ma, input logic [31:0] mw,
    input logic [31:0] ird, input logic [31:0] drd,
    input logic rs = 1'b0);
    vec_t v;
    v.rs = rs; v.ifr = ifr; v.ia = ia;
    v.dr = dr; v.dwe = dwe; v.da = da; v.dw = dw;
    v.f = f; v.ma = ma; v.mw = mw;
    v.ird = ird; v.drd = drd;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic cyc_begin();
    @(posedge clk);
    #1;
    cyc++;
    bus.mem_rdata = (cyc == due) ? due_d : $urandom;
  endtask

  task automatic drive(input logic r, input logic ifr,
                       input logic [31:0] ia,
                       input logic dr, input logic dwe,
                       input logic [31:0] da,
                       input logic [31:0] dw);
    rst         = r;
    bus.if_req  = ifr;
    bus.if_addr = ia;
    bus.d_req   = dr;
    bus.d_we    = dwe;
    bus.d_addr  = da;
    bus.d_wdata = dw;
  endtask

  // memory environment: writes land, reads return after LAT
  task automatic env_update();
    logic [5:0] idx;
    idx = bus.mem_addr[7:2];
    if (rst) due = -1;
    else if (bus.mem_en) begin
      if (bus.mem_we) mem[idx] = bus.mem_wdata;
      else begin
        due   = cyc + LAT;
        due_d = mem[idx];
      end
    end
  endtask

  task automatic chk_out(input string p, input logic [5:0] f,
                         input logic [31:0] ma,
                         input logic [31:0] mw,
                         input logic [31:0] ird,
                         input logic [31:0] drd);
    chk({p, " if_gnt"},    32'(bus.if_gnt),    32'(f[5]));
    chk({p, " d_gnt"},     32'(bus.d_gnt),     32'(f[4]));
    chk({p, " if_rvalid"}, 32'(bus.if_rvalid), 32'(f[3]));
    chk({p, " d_rvalid"},  32'(bus.d_rvalid),  32'(f[2]));
    chk({p, " mem_en"},    32'(bus.mem_en),    32'(f[1]));
    chk({p, " mem_we"},    32'(bus.mem_we),    32'(f[0]));
    chk({p, " mem_addr"},  bus.mem_addr,  ma);
    chk({p, " mem_wdata"}, bus.mem_wdata, mw);
    chk({p, " if_rdata"},  bus.if_rdata,  ird);
    chk({p, " d_rdata"},   bus.d_rdata,   drd);
  endtask

  localparam logic [31:0] A = 32'hAAAA_0001;
  localparam logic [31:0] B = 32'hC0DE_0011;
  localparam logic [31:0] W = 32'h0000_1234;

  // model state for the random phase
  int          nf, rc, stv;
  logic        ro, lst, win_d, g_if, g_d, e_ir, e_dr, r;
  logic [31:0] rdat, e_ird, e_drd;
  logic        ip, dp;
  logic        pdwe;
  logic [31:0] pia, pda, pdw;

  initial begin
    drive(1'b1, 0, 0, 0, 0, 0, 0);
    bus.mem_rdata = '0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + i;
    mem[4] = A;

    // directed vectors
    vq.push_back(V(0,0, 0,0,0,0, 6'b0, 0,0, 0,0, 1'b1));
    vq.push_back(V(0,0, 0,0,0,0, 6'b0, 0,0, 0,0));
    vq.push_back(V(1,'h10, 0,0,0,0, 6'b100010, 'h10,0, 0,0));
    vq.push_back(V(0,0, 0,0,0,0, 6'b0, 0,0, 0,0));
    vq.push_back(V(0,0, 0,0,0,0, 6'b0, 0,0, 0,0));
    vq.push_back(V(0,0, 0,0,0,0, 6'b001000, 0,0, A,0));
    vq.push_back(V(0,0, 1,1,'h40,W, 6'b010011, 'h40,W, A,0));
    vq.push_back(V(0,0, 0,0,0,0, 6'b0, 0,0, A,0));
    vq.push_back(V(0,0, 0,0,0,0, 6'b0, 0,0, A,0));
    vq.push_back(V(0,0, 0,0,0,0, 6'b000100, 0,0, A,0));
    vq.push_back(V(0,0, 1,0,'h40,0, 6'b010010, 'h40,0, A,0));
    vq.push_back(V(0,0, 1,0,'h10,0, 6'b0, 0,0, A,0));
    vq.push_back(V(0,0, 1,0,'h10,0, 6'b0, 0,0, A,0));
    vq.push_back(V(0,0, 1,0,'h10,0, 6'b010110, 'h10,0, A,W));
    vq.push_back(V(0,0, 1,0,'h44,0, 6'b0, 0,0, A,W));
    vq.push_back(V(0,0, 1,0,'h44,0, 6'b0, 0,0, A,W));
    vq.push_back(V(0,0, 1,0,'h44,0, 6'b010110, 'h44,0, A,A));
    vq.push_back(V(0,0, 0,0,0,0, 6'b0, 0,0, A,A));
    vq.push_back(V(0,0, 0,0,0,0, 6'b0, 0,0, A,A));
    vq.push_back(V(0,0, 0,0,0,0, 6'b000100, 0,0, A,B));
    vq.push_back(V(1,'h44, 0,0,0,0, 6'b100010, 'h44,0, A,B));
    vq.push_back(V(0,0, 0,0,0,0, 6'b0, 0,0, 0,0, 1'b1));
    vq.push_back(V(0,0, 0,0,0,0, 6'b0, 0,0, 0,0));
    vq.push_back(V(0,0, 0,0,0,0, 6'b0, 0,0, 0,0));
    vq.push_back(V(0,0, 0,0,0,0, 6'b0, 0,0, 0,0));
    vq.push_back(V(1,'h10, 0,0,0,0, 6'b100010, 'h10,0, 0,0));
    vq.push_back(V(0,0, 0,0,0,0, 6'b0, 0,0, 0,0));
    vq.push_back(V(0,0, 0,0,0,0, 6'b0, 0,0, 0,0));
    vq.push_back(V(0,0, 0,0,0,0, 6'b001000, 0,0, A,0));

    foreach (vq[i]) begin
      cyc_begin();
      drive(vq[i].rs, vq[i].ifr, vq[i].ia, vq[i].dr,
            vq[i].dwe, vq[i].da, vq[i].dw);
      @(negedge clk);
      if (!vq[i].rs)
        chk_out($sformatf("vec%0d", i), vq[i].f, vq[i].ma,
                vq[i].mw, vq[i].ird, vq[i].drd);
      env_update();
    end

    // contention: both requests held continuously
    begin
      int k, last_g;
      logic exp_if;
      k = 0;
      last_g = 0;
      cyc_begin();
      drive(1'b1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      env_update();
      for (int t = 0; t < 200 && k < 10; t++) begin
        cyc_begin();
        drive(1'b0, 1, 'h10, 1, 0, 'h44, 0);
        @(negedge clk);
        if (bus.if_gnt || bus.d_gnt) begin
`ifdef ARB_ROUND_ROBIN_EN
          exp_if = (k % 2 == 1);
`else
          exp_if = (k % (SMAX + 1) == SMAX);
`endif
          chk($sformatf("contention grant %0d", k),
              32'({bus.if_gnt, bus.d_gnt}),
              exp_if ? 32'd2 : 32'd1);
          if (k > 0)
            chk($sformatf("contention spacing %0d", k),
                32'(cyc - last_g), 32'(LAT + 1));
          last_g = cyc;
          k++;
        end
        env_update();
      end
      chk("contention grant count", 32'(k), 32'd10);
    end

    // randomized traffic against the transaction model
    ip = 0; dp = 0;
    pia = 0; pda = 0; pdw = 0; pdwe = 0;
    nf = 0; rc = -1; stv = 0; lst = OWN_IF; ro = OWN_IF;
    rdat = 0; e_ird = 0; e_drd = 0;
    for (int t = 0; t < 3000; t++) begin
      cyc_begin();
      r = (t == 0) || ($urandom_range(0, 199) == 0);
      if (!ip && $urandom_range(0, 2) == 0) begin
        ip  = 1;
        pia = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
      end
      if (!dp && $urandom_range(0, 2) == 0) begin
        dp   = 1;
        pda  = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
        pdw  = $urandom;
        pdwe = 1'($urandom);
      end
      if (r) drive(1'b1, 0, 0, 0, 0, 0, 0);
      else   drive(1'b0, ip, pia, dp, pdwe, pda, pdw);
      @(negedge clk);
      if (r) begin
        ip = 0; dp = 0;
        nf = cyc + 1; rc = -1; stv = 0; lst = OWN_IF;
        e_ird = 0; e_drd = 0;
      end else begin
        e_ir = 0; e_dr = 0; g_if = 0; g_d = 0;
        if (cyc == rc) begin
          if (ro == OWN_IF) begin e_ir = 1; e_ird = rdat; end
          else              begin e_dr = 1; e_drd = rdat; end
        end
        if (cyc >= nf && (ip || dp)) begin
`ifdef ARB_ROUND_ROBIN_EN
          win_d = (ip && dp) ? (lst == OWN_IF) : dp;
          lst = win_d ? OWN_D : OWN_IF;
`else
          win_d = (ip && dp) ? (stv < SMAX) : dp;
          if (!win_d) stv = 0;
          else if (ip) stv = (stv + 1 > SMAX) ? SMAX : stv + 1;
`endif
          if (win_d) begin
            g_d = 1; ro = OWN_D;
            rdat = pdwe ? 32'd0 : mem[pda[7:2]];
          end else begin
            g_if = 1; ro = OWN_IF;
            rdat = mem[pia[7:2]];
          end
          nf = cyc + LAT + 1;
          rc = nf;
        end
        chk_out($sformatf("rand%0d", t),
                {g_if, g_d, e_ir, e_dr, g_if | g_d, g_d & pdwe},
                g_d ? pda : (g_if ? pia : 32'd0),
                g_d ? pdw : 32'd0, e_ird, e_drd);
        if (g_if) ip = 0;
        if (g_d)  dp = 0;
      end
      env_update();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
